fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register.
- Holds the PC and issues word-aligned requests to instruction memory with a valid/ready handshake.
- Captures each returned instruction with its PC into the IF/ID register that feeds decode and immediate generation.
- Supports decode stall via a one-entry hold buffer, and branch/jump redirect with flush.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry stall buffer and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: pulse misalign_err the cycle after a redirect with redirect_pc[1:0]!=0.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        misalign_err
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

   state_t      state, state_n;
   logic [31:0] pc, out_pc, buf_pc, buf_instr, redir_pc;
   logic        buf_valid, accept, resp_take;

   assign imem_req_valid = !rst && (state == REQ) && !buf_valid;
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign resp_take      = (state == WAIT) && imem_resp_valid;
   assign redir_pc       = redirect_pc & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= REQ;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         REQ:     if (accept) state_n = WAIT;
         WAIT:    if (imem_resp_valid) state_n = REQ;
         DROP:    if (imem_resp_valid) state_n = REQ;
         default: state_n = REQ;
      endcase
      // A response landing in the redirect cycle retires the outstanding request,
      // so only a still-pending (or just accepted) request needs a DROP.
      if (redirect_valid) begin
         if ((state == DROP || state == WAIT) && imem_resp_valid) state_n = REQ;
         else if (state == DROP || state == WAIT || accept)        state_n = DROP;
         else                                                      state_n = REQ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         out_pc    <= '0;
         buf_valid <= 1'b0;
         buf_pc    <= '0;
         buf_instr <= NOP;
         id_valid  <= 1'b0;
         id_pc     <= '0;
         id_instr  <= NOP;
      end else if (redirect_valid) begin
         pc        <= redir_pc;
         buf_valid <= 1'b0;
         id_valid  <= 1'b0;
         id_instr  <= NOP;
      end else begin
         if (accept) begin
            pc     <= pc + 32'd4;
            out_pc <= pc;
         end
         // Buffer and response never coincide: requests are blocked while the buffer is full.
         if (buf_valid && !stall) begin
            id_valid  <= 1'b1;
            id_pc     <= buf_pc;
            id_instr  <= buf_instr;
            buf_valid <= 1'b0;
         end else if (resp_take && (!stall || !id_valid)) begin
            id_valid  <= 1'b1;
            id_pc     <= out_pc;
            id_instr  <= imem_resp_data;
         end else if (resp_take) begin
            buf_valid <= 1'b1;
            buf_pc    <= out_pc;
            buf_instr <= imem_resp_data;
         end else if (!stall) begin
            id_valid  <= 1'b0;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else     misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable instruction memory model.
module tb_fetch_stage;
   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready, imem_resp_valid;
   logic [31:0] imem_req_addr, imem_resp_data;
   logic        stall, redirect_valid, id_valid, misalign_err;
   logic [31:0] redirect_pc, id_pc, id_instr;

   int n_chk = 0, n_fail = 0;

   fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // memory model: response appears 'lat' cycles after acceptance
   bit          auto_mem = 1'b1;
   int          lat = 1, cnt = 0;
   logic        pend = 1'b0, acc, mdl_valid = 1'b0, man_valid = 1'b0;
   logic [31:0] paddr, acc_addr, mdl_data = '0, man_data = '0;

   assign imem_resp_valid = auto_mem ? mdl_valid : man_valid;
   assign imem_resp_data  = auto_mem ? mdl_data  : man_data;

   always @(posedge clk) begin
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      #1;
      mdl_valid = 1'b0;
      if (!auto_mem) pend = 1'b0;
      else begin
         if (acc) begin pend = 1'b1; paddr = acc_addr; cnt = lat; end
         if (pend) begin
            cnt--;
            if (cnt == 0) begin mdl_valid = 1'b1; mdl_data = instr_of(paddr); pend = 1'b0; end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; imem_req_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(negedge clk);
      n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
      n_chk++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_addr got %h exp 0", imem_req_addr); end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
      n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
      n_chk++; if (id_instr !== 32'h13) begin n_fail++; $display("FAIL rst_id_instr got %h exp 13", id_instr); end
      n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
   endtask

   task automatic test_stream();
      imem_req_ready = 1'b1; rst = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*k)) begin n_fail++; $display("FAIL stream_req[%0d] got %b/%h exp 1/%h", k, imem_req_valid, imem_req_addr, 4*k); end
         if (k > 0) begin
            n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'(4*(k-1)) || id_instr !== instr_of(32'(4*(k-1)))) begin n_fail++; $display("FAIL stream_id[%0d] got %b/%h/%h", k, id_valid, id_pc, id_instr); end
         end else begin
            n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_id0 got %b exp 0", id_valid); end
         end
         @(negedge clk);
         n_chk++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap[%0d] got req %b id %b exp 0/0", k, imem_req_valid, id_valid); end
         @(negedge clk);
      end
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== instr_of(32'h4)) begin n_fail++; $display("FAIL stream_id4 got %b/%h/%h", id_valid, id_pc, id_instr); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL stream_req8 got %b/%h", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_hold0 got %b/%h exp 1/4", id_valid, id_pc); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_chk++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_buf[%0d] got req %b id %b/%h exp 0 1/4", c, imem_req_valid, id_valid, id_pc); end
      end
      stall = 1'b0;
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== instr_of(32'h8)) begin n_fail++; $display("FAIL stall_drain got %b/%h/%h", id_valid, id_pc, id_instr); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin n_fail++; $display("FAIL stall_reqC got %b/%h", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble got %b exp 0", id_valid); end
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin n_fail++; $display("FAIL stall_idC got %b/%h", id_valid, id_pc); end
      n_chk++; if (imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL stall_req10 got %h exp 10", imem_req_addr); end
   endtask

   task automatic test_redirect();
      lat = 3;
      @(negedge clk);
      n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait got %b exp 0", imem_req_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_chk++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_drop got %b/%h exp 0/100", imem_req_valid, imem_req_addr); end
      n_chk++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin n_fail++; $display("FAIL redir_flush got %b/%h exp 0/13", id_valid, id_instr); end
      @(negedge clk);
      lat = 1;
      n_chk++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale got id %b req %b exp 0/0", id_valid, imem_req_valid); end
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_refetch got %b %b/%h", id_valid, imem_req_valid, imem_req_addr); end
      repeat (2) @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin n_fail++; $display("FAIL redir_id100 got %b/%h/%h", id_valid, id_pc, id_instr); end
   endtask

   task automatic test_redirect_stall_buf();
      stall = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (imem_req_valid !== 1'b0 || id_pc !== 32'h100) begin n_fail++; $display("FAIL rsb_full got %b/%h exp 0/100", imem_req_valid, id_pc); end
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_chk++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin n_fail++; $display("FAIL rsb_flush got %b/%h exp 0/13", id_valid, id_instr); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rsb_pc got %b/%h exp 1/200", imem_req_valid, imem_req_addr); end
      stall = 1'b0;
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rsb_bufgone got %b/%h exp 0", id_valid, id_pc); end
      @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_fail++; $display("FAIL rsb_id200 got %b/%h", id_valid, id_pc); end
   endtask

   task automatic test_misalign();
      logic exp_err;
`ifdef FETCH_ALIGN_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_chk++; if (misalign_err !== exp_err) begin n_fail++; $display("FAIL mis_pulse got %b exp %b", misalign_err, exp_err); end
      n_chk++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mis_drop got %b/%h id %b", imem_req_valid, imem_req_addr, id_valid); end
      @(negedge clk);
      n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_once got %b exp 0", misalign_err); end
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mis_refetch got %b/%h id %b", imem_req_valid, imem_req_addr, id_valid); end
      repeat (2) @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL mis_id100 got %b/%h", id_valid, id_pc); end
   endtask

   task automatic test_reset_mid();
      lat = 3;
      @(negedge clk);
      n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait got %b exp 0", imem_req_valid); end
      auto_mem = 1'b0; man_valid = 1'b0; rst = 1'b1; #1;
      n_chk++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rm_req got %b/%h exp 0/0", imem_req_valid, imem_req_addr); end
      n_chk++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h13) begin n_fail++; $display("FAIL rm_id got %b/%h/%h", id_valid, id_pc, id_instr); end
      @(negedge clk);
      rst = 1'b0; imem_req_ready = 1'b0; #1;
      n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rm_first got %b/%h exp 1/0", imem_req_valid, imem_req_addr); end
      man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
      @(negedge clk);
      man_valid = 1'b0;
      n_chk++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rm_stale got id %b req %b/%h", id_valid, imem_req_valid, imem_req_addr); end
      lat = 1; auto_mem = 1'b1; imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin n_fail++; $display("FAIL rm_id0 got %b/%h/%h", id_valid, id_pc, id_instr); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_stall_buf();
      test_misalign();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
